// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexed 7-segment scan driver. Each digit owns one slot of SCAN_DIV
// cycles; the first BLANK_CYC cycles of every slot are dark to suppress ghosting.
// Digits 0..NUM_DIGITS/2-1 drive seg_lo, the rest drive seg_hi. New codes are
// loaded into a pending buffer and committed only at the frame boundary, so a
// frame is never torn.
// Optional feature: define SEG_DIM_EN to add the 3-bit 'bright' input, which
// shortens the lit part of each slot to (bright+1)/8 of its non-blank length.

`ifndef DIGIT0
`define DIGIT0     8'h3f
`define DIGIT1     8'h06
`define DIGIT2     8'h5b
`define DIGIT3     8'h4f
`define DIGIT4     8'h66
`define DIGIT5     8'h6d
`define DIGIT6     8'h7d
`define DIGIT7     8'h07
`define DIGIT8     8'h7f
`define DIGIT9     8'h6f
`define DIGITA     8'h77
`define DIGITU     8'h3e
`define DIGITC     8'h39
`define DIGITL     8'h38
`define DIGITE     8'h79
`define DIGIT_NULL 8'h00
`endif

module seg_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 25000,
    parameter int BLANK_CYC  = 500,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] codes,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`ifdef SEG_DIM_EN
    input  logic [2:0]              bright,
`endif
    output logic [7:0]              seg_lo,
    output logic [7:0]              seg_hi,
    output logic [NUM_DIGITS-1:0]   tub_sel,
    output logic                    frame_tick,
    output logic                    upd_done
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0]         SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]         BLANK_END  = SW'(BLANK_CYC);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0]         IDX_HALF   = IW'(NUM_DIGITS / 2);
    localparam logic [BW-1:0]         BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] TUB_ONE    = NUM_DIGITS'(1);

    logic [SW-1:0]           slot_cnt;
    logic [IW-1:0]           idx;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_ph;
    logic [4*NUM_DIGITS-1:0] disp_codes;
    logic [4*NUM_DIGITS-1:0] pend_codes;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_valid;
    logic                    slot_wrap;
    logic                    boundary;
    logic                    lit_win;

    logic [3:0]              cur_code;
    logic [7:0]              cur_glyph;
    logic                    digit_on;
    logic                    seg_on;
    logic [NUM_DIGITS-1:0]   tub_nxt;
    logic [7:0]              seg_lo_nxt;
    logic [7:0]              seg_hi_nxt;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign boundary  = slot_wrap && (idx == IDX_LAST);

    function automatic logic [7:0] glyph(input logic [3:0] code);
        logic [7:0] g;
        case (code)
            4'h0:    g = `DIGIT0;
            4'h1:    g = `DIGIT1;
            4'h2:    g = `DIGIT2;
            4'h3:    g = `DIGIT3;
            4'h4:    g = `DIGIT4;
            4'h5:    g = `DIGIT5;
            4'h6:    g = `DIGIT6;
            4'h7:    g = `DIGIT7;
            4'h8:    g = `DIGIT8;
            4'h9:    g = `DIGIT9;
            4'hA:    g = `DIGITA;
            4'hB:    g = `DIGITU;
            4'hC:    g = `DIGITC;
            4'hD:    g = `DIGITL;
            4'hE:    g = `DIGITE;
            default: g = `DIGIT_NULL;
        endcase
        return g;
    endfunction

    // Slot counter and digit index; they free-run regardless of en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Blink half-period timer and phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Pending/display double buffer. At a boundary the old pending data commits
    // even if a new load lands in the same cycle; that load stays pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_codes <= '1;
            disp_dp    <= '0;
            pend_codes <= '1;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (boundary && pend_valid) begin
                disp_codes <= pend_codes;
                disp_dp    <= pend_dp;
            end
            if (load) begin
                pend_codes <= codes;
                pend_dp    <= dp;
                pend_valid <= 1'b1;
            end else if (boundary) begin
                pend_valid <= 1'b0;
            end
        end
    end

`ifdef SEG_DIM_EN
    localparam int LW       = SW + 1;
    localparam int LIT_SPAN = SCAN_DIV - BLANK_CYC;

    logic [LW-1:0] lit_len;
    logic [LW-1:0] lit_len_nxt;
    logic [SW-1:0] slot_off;

    assign lit_len_nxt = LW'(((int'(bright) + 1) * LIT_SPAN) >> 3);
    assign slot_off    = slot_cnt - BLANK_END;
    assign lit_win     = ({1'b0, slot_off} < lit_len);

    // Brightness is latched at slot start so a slot's lit length never changes mid-slot.
    always_ff @(posedge clk) begin
        if (!rst || slot_wrap) begin
            lit_len <= lit_len_nxt;
        end
    end
`else
    assign lit_win = 1'b1;
`endif

    // Next values for the output registers, derived from the current counter state.
    always_comb begin
        cur_code   = disp_codes[{idx, 2'b00} +: 4];
        cur_glyph  = glyph(cur_code) | {disp_dp[idx], 7'b0};
        digit_on   = en && (slot_cnt >= BLANK_END) && lit_win;
        seg_on     = digit_on && !(blink_ph && blink_mask[idx]);
        tub_nxt    = '0;
        seg_lo_nxt = 8'h00;
        seg_hi_nxt = 8'h00;
        if (digit_on) begin
            tub_nxt = TUB_ONE << idx;
        end
        if (seg_on) begin
            if (idx < IDX_HALF) begin
                seg_lo_nxt = cur_glyph;
            end else begin
                seg_hi_nxt = cur_glyph;
            end
        end
    end

    // Output registers: digit select, segment buses and the boundary pulses move together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tub_sel    <= '0;
            seg_lo     <= 8'h00;
            seg_hi     <= 8'h00;
            frame_tick <= 1'b0;
            upd_done   <= 1'b0;
        end else begin
            tub_sel    <= tub_nxt;
            seg_lo     <= seg_lo_nxt;
            seg_hi     <= seg_hi_nxt;
            frame_tick <= boundary;
            upd_done   <= boundary && pend_valid;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NUM_DIGITS=4, SCAN_DIV=10,
// BLANK_CYC=2, BLINK_DIV=100. 't' counts clock edges since reset release, so
// after t edges the outputs reflect counter state t-1:
// slot=(t-1)%10, digit=((t-1)/10)%4, blink phase=((t-1)/100)%2.
module tb_seg_scan_driver;

    localparam logic [7:0] G0 = 8'h3f;
    localparam logic [7:0] G1 = 8'h06;
    localparam logic [7:0] G2 = 8'h5b;
    localparam logic [7:0] G3 = 8'h4f;
    localparam logic [7:0] G4 = 8'h66;
    localparam logic [7:0] G5 = 8'h6d;
    localparam logic [7:0] G6 = 8'h7d;
    localparam logic [7:0] G7 = 8'h07;
    localparam logic [7:0] G8 = 8'h7f;
    localparam logic [7:0] G9 = 8'h6f;
    localparam logic [7:0] GA = 8'h77;
    localparam logic [7:0] GU = 8'h3e;
    localparam logic [7:0] GC = 8'h39;
    localparam logic [7:0] GL = 8'h38;
    localparam logic [7:0] GE = 8'h79;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [15:0] codes = 16'h0000;
    logic [3:0]  dp = 4'b0000;
    logic [3:0]  blink_mask = 4'b0000;
`ifdef SEG_DIM_EN
    logic [2:0]  bright = 3'd7;
`endif
    logic [7:0]  seg_lo;
    logic [7:0]  seg_hi;
    logic [3:0]  tub_sel;
    logic        frame_tick;
    logic        upd_done;

    int checks = 0;
    int failures = 0;
    int t = 0;
    int upd_cnt = 0;
    int u0;

    seg_scan_driver #(
        .NUM_DIGITS(4),
        .SCAN_DIV(10),
        .BLANK_CYC(2),
        .BLINK_DIV(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .load(load),
        .codes(codes),
        .dp(dp),
        .blink_mask(blink_mask),
`ifdef SEG_DIM_EN
        .bright(bright),
`endif
        .seg_lo(seg_lo),
        .seg_hi(seg_hi),
        .tub_sel(tub_sel),
        .frame_tick(frame_tick),
        .upd_done(upd_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) t <= rst ? t + 1 : 0;

    always @(negedge clk) if (upd_done === 1'b1) upd_cnt++;

    task automatic goto(input int n);
        while (t < n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] c, input logic [3:0] d);
        codes = c;
        dp    = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tub_sel !== 4'b0000) begin failures++; $display("FAIL rst_tub got=%b exp=0000", tub_sel); end
        checks++; if (seg_lo !== 8'h00) begin failures++; $display("FAIL rst_seg_lo got=%h exp=00", seg_lo); end
        checks++; if (seg_hi !== 8'h00) begin failures++; $display("FAIL rst_seg_hi got=%h exp=00", seg_hi); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL rst_frame_tick got=%b exp=0", frame_tick); end
        checks++; if (upd_done !== 1'b0) begin failures++; $display("FAIL rst_upd_done got=%b exp=0", upd_done); end
        rst = 1'b1;
        goto(2);
        checks++; if (tub_sel !== 4'b0000) begin failures++; $display("FAIL rel2_tub got=%b exp=0000", tub_sel); end
        goto(3);
        checks++; if (tub_sel !== 4'b0001) begin failures++; $display("FAIL rel3_tub got=%b exp=0001", tub_sel); end
        checks++; if (seg_lo !== 8'h00) begin failures++; $display("FAIL rel3_blank got=%h exp=00", seg_lo); end
        goto(10);
        checks++; if (tub_sel !== 4'b0001) begin failures++; $display("FAIL rel10_tub got=%b exp=0001", tub_sel); end
        goto(11);
        checks++; if (tub_sel !== 4'b0000) begin failures++; $display("FAIL rel11_blankint got=%b exp=0000", tub_sel); end
        goto(13);
        checks++; if (tub_sel !== 4'b0010) begin failures++; $display("FAIL rel13_tub got=%b exp=0010", tub_sel); end
    endtask

    task automatic test_load;
        goto(15);
        u0 = upd_cnt;
        pulse_load(16'h3210, 4'b0100);
        goto(23);
        checks++; if (seg_hi !== 8'h00) begin failures++; $display("FAIL load_midframe seg_hi got=%h exp=00", seg_hi); end
        goto(39);
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL load_tick_early got=%b exp=0", frame_tick); end
        goto(40);
        checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL load_tick got=%b exp=1", frame_tick); end
        checks++; if (upd_done !== 1'b1) begin failures++; $display("FAIL load_upd got=%b exp=1", upd_done); end
        goto(41);
        checks++; if ({frame_tick, upd_done} !== 2'b00) begin failures++; $display("FAIL load_pulse_width got=%b exp=00", {frame_tick, upd_done}); end
        goto(43);
        checks++; if (seg_lo !== G0) begin failures++; $display("FAIL load_d0 seg_lo got=%h exp=%h", seg_lo, G0); end
        checks++; if (seg_hi !== 8'h00) begin failures++; $display("FAIL load_d0 seg_hi got=%h exp=00", seg_hi); end
        goto(53);
        checks++; if (seg_lo !== G1) begin failures++; $display("FAIL load_d1 seg_lo got=%h exp=%h", seg_lo, G1); end
        checks++; if (tub_sel !== 4'b0010) begin failures++; $display("FAIL load_d1 tub got=%b exp=0010", tub_sel); end
        goto(63);
        checks++; if (seg_hi !== (G2 | 8'h80)) begin failures++; $display("FAIL load_d2_dp seg_hi got=%h exp=%h", seg_hi, G2 | 8'h80); end
        checks++; if (seg_lo !== 8'h00) begin failures++; $display("FAIL load_d2 seg_lo got=%h exp=00", seg_lo); end
        goto(73);
        checks++; if (seg_hi !== G3) begin failures++; $display("FAIL load_d3 seg_hi got=%h exp=%h", seg_hi, G3); end
        goto(80);
        checks++; if (upd_cnt - u0 !== 1) begin failures++; $display("FAIL load_upd_count got=%0d exp=1", upd_cnt - u0); end
    endtask

    task automatic test_back_to_back;
        goto(85);
        u0 = upd_cnt;
        pulse_load(16'h1111, 4'b1111);
        goto(90);
        pulse_load(16'h2222, 4'b0000);
        goto(123);
        checks++; if (seg_lo !== G2) begin failures++; $display("FAIL b2b_d0 got=%h exp=%h", seg_lo, G2); end
        goto(133);
        checks++; if (seg_lo !== G2) begin failures++; $display("FAIL b2b_d1 got=%h exp=%h", seg_lo, G2); end
        goto(153);
        checks++; if (seg_hi !== G2) begin failures++; $display("FAIL b2b_d3 got=%h exp=%h", seg_hi, G2); end
        goto(159);
        checks++; if (upd_cnt - u0 !== 1) begin failures++; $display("FAIL b2b_upd_count got=%0d exp=1", upd_cnt - u0); end
    endtask

    task automatic test_boundary_load;
        goto(170);
        pulse_load(16'h4567, 4'b0000);
        goto(199);
        pulse_load(16'h89AB, 4'b0000);
        checks++; if (upd_done !== 1'b1) begin failures++; $display("FAIL bnd_upd1 got=%b exp=1", upd_done); end
        goto(203);
        checks++; if (seg_lo !== G7) begin failures++; $display("FAIL bnd_old_d0 got=%h exp=%h", seg_lo, G7); end
        goto(213);
        checks++; if (seg_lo !== G6) begin failures++; $display("FAIL bnd_old_d1 got=%h exp=%h", seg_lo, G6); end
        goto(223);
        checks++; if (seg_hi !== G5) begin failures++; $display("FAIL bnd_old_d2 got=%h exp=%h", seg_hi, G5); end
        goto(233);
        checks++; if (seg_hi !== G4) begin failures++; $display("FAIL bnd_old_d3 got=%h exp=%h", seg_hi, G4); end
        goto(240);
        checks++; if (upd_done !== 1'b1) begin failures++; $display("FAIL bnd_upd2 got=%b exp=1", upd_done); end
        goto(243);
        checks++; if (seg_lo !== GU) begin failures++; $display("FAIL bnd_new_d0 got=%h exp=%h", seg_lo, GU); end
        goto(253);
        checks++; if (seg_lo !== GA) begin failures++; $display("FAIL bnd_new_d1 got=%h exp=%h", seg_lo, GA); end
        goto(263);
        checks++; if (seg_hi !== G9) begin failures++; $display("FAIL bnd_new_d2 got=%h exp=%h", seg_hi, G9); end
        goto(273);
        checks++; if (seg_hi !== G8) begin failures++; $display("FAIL bnd_new_d3 got=%h exp=%h", seg_hi, G8); end
        goto(280);
        checks++; if (upd_done !== 1'b0) begin failures++; $display("FAIL bnd_no_upd3 got=%b exp=0", upd_done); end
    endtask

    task automatic test_blink_en;
        goto(285);
        blink_mask = 4'b0001;
        pulse_load(16'hFEDC, 4'b1000);
        goto(323);
        checks++; if (tub_sel !== 4'b0001) begin failures++; $display("FAIL blink_tub got=%b exp=0001", tub_sel); end
        checks++; if (seg_lo !== 8'h00) begin failures++; $display("FAIL blink_off got=%h exp=00", seg_lo); end
        goto(333);
        checks++; if (seg_lo !== GL) begin failures++; $display("FAIL blink_d1_unmasked got=%h exp=%h", seg_lo, GL); end
        goto(343);
        checks++; if (seg_hi !== GE) begin failures++; $display("FAIL glyph_e got=%h exp=%h", seg_hi, GE); end
        goto(353);
        checks++; if (seg_hi !== 8'h80) begin failures++; $display("FAIL null_dp got=%h exp=80", seg_hi); end
        goto(403);
        checks++; if (seg_lo !== GC) begin failures++; $display("FAIL blink_on got=%h exp=%h", seg_lo, GC); end
        goto(405);
        en = 1'b0;
        goto(410);
        pulse_load(16'h0000, 4'b0000);
        goto(413);
        checks++; if (tub_sel !== 4'b0000) begin failures++; $display("FAIL en0_tub got=%b exp=0000", tub_sel); end
        checks++; if ({seg_lo, seg_hi} !== 16'h0000) begin failures++; $display("FAIL en0_seg got=%h exp=0000", {seg_lo, seg_hi}); end
        goto(420);
        en = 1'b1;
        goto(423);
        checks++; if (tub_sel !== 4'b0100) begin failures++; $display("FAIL en1_tub got=%b exp=0100", tub_sel); end
        checks++; if (seg_hi !== GE) begin failures++; $display("FAIL en1_seg got=%h exp=%h", seg_hi, GE); end
        goto(440);
        checks++; if (upd_done !== 1'b1) begin failures++; $display("FAIL en0_load_upd got=%b exp=1", upd_done); end
        goto(443);
        checks++; if (seg_lo !== G0) begin failures++; $display("FAIL en0_load_d0 got=%h exp=%h", seg_lo, G0); end
        goto(523);
        checks++; if (tub_sel !== 4'b0001) begin failures++; $display("FAIL blink2_tub got=%b exp=0001", tub_sel); end
        checks++; if (seg_lo !== 8'h00) begin failures++; $display("FAIL blink2_off got=%h exp=00", seg_lo); end
        goto(533);
        checks++; if (seg_lo !== G0) begin failures++; $display("FAIL blink2_d1 got=%h exp=%h", seg_lo, G0); end
    endtask

`ifdef SEG_DIM_EN
    task automatic test_dim;
        goto(555);
        bright = 3'd3;
        goto(562);
        checks++; if (tub_sel !== 4'b0000) begin failures++; $display("FAIL dim_s1 got=%b exp=0000", tub_sel); end
        goto(563);
        checks++; if (tub_sel !== 4'b0001) begin failures++; $display("FAIL dim_s2 got=%b exp=0001", tub_sel); end
        goto(566);
        checks++; if (tub_sel !== 4'b0001) begin failures++; $display("FAIL dim_s5 got=%b exp=0001", tub_sel); end
        goto(567);
        checks++; if (tub_sel !== 4'b0000) begin failures++; $display("FAIL dim_s6 got=%b exp=0000", tub_sel); end
        bright = 3'd7;
    endtask
`endif

    task automatic test_reset_midframe;
        goto(575);
        blink_mask = 4'b0000;
        pulse_load(16'h1234, 4'b1111);
        goto(585);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({tub_sel, frame_tick, upd_done} !== 6'b0) begin failures++; $display("FAIL midrst_out got=%b exp=000000", {tub_sel, frame_tick, upd_done}); end
        rst = 1'b1;
        goto(3);
        checks++; if (tub_sel !== 4'b0001) begin failures++; $display("FAIL midrst_tub got=%b exp=0001", tub_sel); end
        checks++; if (seg_lo !== 8'h00) begin failures++; $display("FAIL midrst_blank got=%h exp=00", seg_lo); end
        goto(40);
        checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL midrst_tick got=%b exp=1", frame_tick); end
        checks++; if (upd_done !== 1'b0) begin failures++; $display("FAIL midrst_discard got=%b exp=0", upd_done); end
        goto(63);
        checks++; if (seg_hi !== 8'h00) begin failures++; $display("FAIL midrst_d2 got=%h exp=00", seg_hi); end
    endtask

    initial begin
        test_reset;
        test_load;
        test_back_to_back;
        test_boundary_load;
        test_blink_en;
`ifdef SEG_DIM_EN
        test_dim;
`endif
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
